// File: rtl/sra_pkg.sv
// Shared definitions for the SRA control path: FSM states, control-word
// field layout, AU opcodes and the per-state control words.
package sra_pkg;

  // Control word width; the datapath decodes exactly this many bits.
  localparam int CW_WIDTH = 20;

  typedef logic [CW_WIDTH-1:0] cw_t;
  typedef logic [1:0]          au_op_t;

  // Register write enables, MSB first.
  localparam int W_R1_BIT    = 19;
  localparam int W_R2_BIT    = 18;
  localparam int W_R3_BIT    = 17;
  localparam int W_R4_BIT    = 16;
  localparam int W_R5_BIT    = 15;

  // Multiplexer selects.
  localparam int S0_R1_BIT   = 14;
  localparam int S1_R1_BIT   = 13;
  localparam int S0_R2_BIT   = 12;
  localparam int S1_R2_BIT   = 11;
  localparam int S0_BAU1_BIT = 10;
  localparam int S1_BAU1_BIT = 9;
  localparam int S0_R5_BIT   = 8;
  localparam int S1_R5_BIT   = 7;
  localparam int S0_AAU2_BIT = 6;
  localparam int S1_AAU2_BIT = 5;

  // Opcode fields (LSB positions, 2 bits each) and output enable.
  localparam int AU1_LSB     = 3;
  localparam int AU2_LSB     = 1;
  localparam int OE_BIT      = 0;

  // AU1 opcodes.
  localparam au_op_t AU1_ABS = 2'b00;  // |B|
  localparam au_op_t AU1_MAX = 2'b01;  // max(A,B)
  localparam au_op_t AU1_MIN = 2'b10;  // min(A,B)
  localparam au_op_t AU1_A   = 2'b11;  // pass A

  // AU2 opcodes.
  localparam au_op_t AU2_ADD = 2'b00;  // A+B
  localparam au_op_t AU2_SUB = 2'b01;  // A-B
  localparam au_op_t AU2_MAX = 2'b10;  // max(A,B)
  localparam au_op_t AU2_B   = 2'b11;  // pass B

  // One micro-step per state, visited in declaration order after IDLE.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LOAD = 4'd1,
    ST_ABS1 = 4'd2,
    ST_ABS2 = 4'd3,
    ST_MAXX = 4'd4,
    ST_MINY = 4'd5,
    ST_SUB  = 4'd6,
    ST_ADD  = 4'd7,
    ST_MAX2 = 4'd8,
    ST_DONE = 4'd9
  } state_t;

  // Single-bit control-word mask.
  function automatic cw_t cw_bit(input int pos);
    return cw_t'(1) << pos;
  endfunction

  // Opcode placed into its field.
  function automatic cw_t cw_op(input au_op_t op, input int lsb);
    return cw_t'(op) << lsb;
  endfunction

  // Per-state control words, assembled from the field positions so the
  // layout is described once.
  localparam cw_t CW_IDLE = '0;
  localparam cw_t CW_LOAD = cw_bit(W_R1_BIT) | cw_bit(W_R2_BIT)
                          | cw_bit(S0_R1_BIT) | cw_bit(S0_R2_BIT);            // 0xC5000
  localparam cw_t CW_ABS1 = cw_bit(W_R1_BIT) | cw_bit(S1_R1_BIT)
                          | cw_bit(S0_BAU1_BIT) | cw_op(AU1_ABS, AU1_LSB);    // 0x82400
  localparam cw_t CW_ABS2 = cw_bit(W_R2_BIT) | cw_bit(S1_R2_BIT)
                          | cw_bit(S1_BAU1_BIT) | cw_op(AU1_ABS, AU1_LSB);    // 0x40A00
  localparam cw_t CW_MAXX = cw_bit(W_R4_BIT) | cw_bit(W_R5_BIT)
                          | cw_bit(S0_R5_BIT) | cw_bit(S1_BAU1_BIT)
                          | cw_op(AU1_MAX, AU1_LSB);                          // 0x18308
  localparam cw_t CW_MINY = cw_bit(W_R3_BIT) | cw_bit(S1_BAU1_BIT)
                          | cw_op(AU1_MIN, AU1_LSB);                          // 0x20210
  localparam cw_t CW_SUB  = cw_bit(W_R5_BIT) | cw_bit(S1_R5_BIT)
                          | cw_bit(S0_AAU2_BIT) | cw_op(AU2_SUB, AU2_LSB);    // 0x080C2
  localparam cw_t CW_ADD  = cw_bit(W_R5_BIT) | cw_bit(S1_R5_BIT)
                          | cw_bit(S1_AAU2_BIT) | cw_op(AU2_ADD, AU2_LSB);    // 0x080A0
  localparam cw_t CW_MAX2 = cw_bit(W_R5_BIT) | cw_bit(S1_R5_BIT)
                          | cw_bit(S0_AAU2_BIT) | cw_op(AU2_MAX, AU2_LSB);    // 0x080C4
  localparam cw_t CW_DONE = cw_bit(OE_BIT);                                  // 0x00001

endpackage

// File: rtl/sra_controller_if.sv
// Handshake and control-word bundle between the SRA requester, the
// controller and the datapath.
interface sra_controller_if;
  logic            start;
  logic            busy;
  logic            done;
  sra_pkg::cw_t    ctrl_word;

  // Requester side: raises start, watches busy/done and the control word.
  modport master (
    output start,
    input  busy,
    input  done,
    input  ctrl_word
  );

  // Controller side.
  modport slave (
    input  start,
    output busy,
    output done,
    output ctrl_word
  );
endinterface

// File: rtl/sra_controller.sv
// Sequencing FSM for the square-root-approximation datapath. One micro-step
// per clock; all outputs are decoded from the registered state only.
module sra_controller
  import sra_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sra_controller_if.slave   bus
);

  state_t state_reg;
  state_t state_next;
  cw_t    ctrl_word_next;
  logic   busy_next;
  logic   done_next;

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Moore output decode. start only matters in IDLE/DONE,
  // and it feeds state_next only, never the outputs.
  always_comb begin
    state_next     = state_reg;
    ctrl_word_next = CW_IDLE;
    busy_next      = 1'b1;
    done_next      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        busy_next  = 1'b0;
        state_next = bus.start ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        ctrl_word_next = CW_LOAD;
        state_next     = ST_ABS1;
      end
      ST_ABS1: begin
        ctrl_word_next = CW_ABS1;
        state_next     = ST_ABS2;
      end
      ST_ABS2: begin
        ctrl_word_next = CW_ABS2;
        state_next     = ST_MAXX;
      end
      ST_MAXX: begin
        ctrl_word_next = CW_MAXX;
        state_next     = ST_MINY;
      end
      ST_MINY: begin
        ctrl_word_next = CW_MINY;
        state_next     = ST_SUB;
      end
      ST_SUB: begin
        ctrl_word_next = CW_SUB;
        state_next     = ST_ADD;
      end
      ST_ADD: begin
        ctrl_word_next = CW_ADD;
        state_next     = ST_MAX2;
      end
      ST_MAX2: begin
        ctrl_word_next = CW_MAX2;
        state_next     = ST_DONE;
      end
      ST_DONE: begin
        ctrl_word_next = CW_DONE;
        done_next      = 1'b1;
        // Back-to-back: go straight to LOAD so OE is low in that cycle.
        state_next     = bus.start ? ST_LOAD : ST_IDLE;
      end
      default: begin
        // Unused encodings fall back to IDLE.
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.ctrl_word = ctrl_word_next;
  assign bus.busy      = busy_next;
  assign bus.done      = done_next;

endmodule

// File: tb/tb_sra_controller.sv
// Directed checks of the SRA controller's control-word sequence, handshake
// outputs, start filtering, back-to-back operation and reset behaviour.
module tb_sra_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cycle;

  logic [19:0] exp_seq [0:8];

  sra_controller_if bus ();

  sra_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.ctrl_word !== 20'h00000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got cw=%05h busy=%b done=%b, expected cw=00000 busy=0 done=0",
                 i, bus.ctrl_word, bus.busy, bus.done);
      end
      tick();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.ctrl_word !== 20'h00000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got cw=%05h busy=%b, expected cw=00000 busy=0",
               bus.ctrl_word, bus.busy);
    end
  endtask

  // Walk the nine working states starting from LOAD (already current),
  // checking each control word, busy and done. Leaves the FSM in the
  // cycle after DONE. start is set to start_at_done while in DONE.
  task automatic run_sequence(input string tag, input logic start_at_done);
    int done_cnt;
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus.ctrl_word !== exp_seq[i] || bus.busy !== 1'b1 || bus.done !== (i == 8)) begin
        errors++;
        $display("FAIL %s step%0d: got cw=%05h busy=%b done=%b, expected cw=%05h busy=1 done=%b",
                 tag, i, bus.ctrl_word, bus.busy, bus.done, exp_seq[i], (i == 8));
      end
      if (bus.done === 1'b1) done_cnt++;
      if (i == 8) bus.start = start_at_done;
      tick();
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d, expected 1", tag, done_cnt);
    end
    $display("%s: result cycle completed at cycle %0d", tag, cycle - 1);
  endtask

  task automatic test_single();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_sequence("single", 1'b0);
    checks++;
    if (bus.ctrl_word !== 20'h00000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got cw=%05h busy=%b done=%b, expected cw=00000 busy=0 done=0",
               bus.ctrl_word, bus.busy, bus.done);
    end
  endtask

  task automatic test_ignore_start();
    bus.start = 1'b1;
    tick();                 // LOAD
    bus.start = 1'b0;
    tick();                 // ABS1
    tick();                 // ABS2
    checks++;
    if (bus.ctrl_word !== 20'h40A00) begin
      errors++;
      $display("FAIL ignore_abs2: got cw=%05h, expected 40A00", bus.ctrl_word);
    end
    bus.start = 1'b1;       // pulse during ABS2
    tick();                 // MAXX
    bus.start = 1'b0;
    checks++;
    if (bus.ctrl_word !== 20'h18308) begin
      errors++;
      $display("FAIL ignore_maxx: got cw=%05h, expected 18308", bus.ctrl_word);
    end
    tick();                 // MINY
    tick();                 // SUB
    bus.start = 1'b1;       // pulse during SUB
    tick();                 // ADD
    bus.start = 1'b0;
    checks++;
    if (bus.ctrl_word !== 20'h080A0) begin
      errors++;
      $display("FAIL ignore_add: got cw=%05h, expected 080A0", bus.ctrl_word);
    end
    tick();                 // MAX2
    tick();                 // DONE
    checks++;
    if (bus.ctrl_word !== 20'h00001 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done: got cw=%05h done=%b, expected cw=00001 done=1",
               bus.ctrl_word, bus.done);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.ctrl_word !== 20'h00000) begin
      errors++;
      $display("FAIL ignore_idle: got cw=%05h busy=%b, expected cw=00000 busy=0",
               bus.ctrl_word, bus.busy);
    end
    // Stay idle with no start.
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_stay_idle: got busy=%b, expected 0", bus.busy);
    end
    $display("ignore_start: single result, back to idle at cycle %0d", cycle);
  endtask

  task automatic test_back_to_back();
    int first_done;
    bus.start = 1'b1;
    tick();                              // LOAD #1
    run_sequence("b2b_first", 1'b1);     // DONE -> LOAD
    first_done = cycle - 1;
    run_sequence("b2b_second", 1'b0);    // DONE -> IDLE
    checks++;
    if ((cycle - 1) - first_done != 9) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, expected 9", (cycle - 1) - first_done);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1;
    tick();                              // LOAD
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();  // ABS1..ADD
    checks++;
    if (bus.ctrl_word !== 20'h080A0) begin
      errors++;
      $display("FAIL rstmid_add: got cw=%05h, expected 080A0", bus.ctrl_word);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.ctrl_word !== 20'h00000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got cw=%05h busy=%b done=%b, expected cw=00000 busy=0 done=0",
               bus.ctrl_word, bus.busy, bus.done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.ctrl_word !== 20'h00000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: got cw=%05h busy=%b, expected cw=00000 busy=0",
               bus.ctrl_word, bus.busy);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_sequence("after_reset", 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    exp_seq[0] = 20'hC5000;
    exp_seq[1] = 20'h82400;
    exp_seq[2] = 20'h40A00;
    exp_seq[3] = 20'h18308;
    exp_seq[4] = 20'h20210;
    exp_seq[5] = 20'h080C2;
    exp_seq[6] = 20'h080A0;
    exp_seq[7] = 20'h080C4;
    exp_seq[8] = 20'h00001;
    rst = 1'b1;
    bus.start = 1'b0;

    test_reset();
    test_single();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
